// File: rtl/pulse_scan_pkg.sv
// Shared types and constants for the pulse scan sequencer.
// State encoding, default widths and the reset delay value.
package pulse_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DW_DEF = 16;
    localparam int CW_DEF = 16;

    localparam int unsigned DEL_RST = 0;

endpackage

// File: rtl/pulse_scan_sequencer.sv
// Steps the pulse generator delay across a programmed point/shot grid.
// Build option SCAN_DIR_EN adds a scan_down input (decrementing scan).
module pulse_scan_sequencer
    import pulse_scan_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          period_tick,
`ifdef SCAN_DIR_EN
    input  logic          scan_down,
`endif
    input  logic [DW-1:0] del_start,
    input  logic [DW-1:0] del_step,
    input  logic [CW-1:0] n_points,
    input  logic [CW-1:0] n_shots,
    output logic [DW-1:0] del,
    output logic          arm,
    output logic [CW-1:0] point_idx,
    output logic [CW-1:0] shot_idx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t state_q, state_n;

    logic [DW-1:0] del_q, del_n;
    logic [CW-1:0] pt_q, pt_n;
    logic [CW-1:0] shot_q, shot_n;
    logic          arm_q, arm_n;
    logic          err_q, err_n;
    logic          busy_q, done_q;
    logic          load;

    logic [DW-1:0] sh_start;
    logic [DW-1:0] sh_step;
    logic [CW-1:0] sh_points;
    logic [CW-1:0] sh_shots;
    logic          sh_down;

    logic [DW:0]   nxt_del;
    logic          last_shot;
    logic          last_point;
    logic          cfg_zero;

    // Shadow snapshot: only the start-time configuration drives a scan
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_start  <= '0;
            sh_step   <= '0;
            sh_points <= '0;
            sh_shots  <= '0;
        end else if (load) begin
            sh_start  <= del_start;
            sh_step   <= del_step;
            sh_points <= n_points;
            sh_shots  <= n_shots;
        end
    end

`ifdef SCAN_DIR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_down <= 1'b0;
        end else if (load) begin
            sh_down <= scan_down;
        end
    end
`else
    assign sh_down = 1'b0;
`endif

    // Bit DW is the carry (up) or borrow (down) of the next point delay
    always_comb begin
        if (sh_down) begin
            nxt_del = {1'b0, del_q} - {1'b0, sh_step};
        end else begin
            nxt_del = {1'b0, del_q} + {1'b0, sh_step};
        end
    end

    assign last_shot  = (shot_q == sh_shots - CW'(1));
    assign last_point = (pt_q == sh_points - CW'(1));
    assign cfg_zero   = (n_points == '0) || (n_shots == '0);

    always_comb begin
        state_n = state_q;
        del_n   = del_q;
        pt_n    = pt_q;
        shot_n  = shot_q;
        arm_n   = arm_q;
        err_n   = err_q;
        load    = 1'b0;
        if (abort) begin
            state_n = IDLE;
            arm_n   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        load  = 1'b1;
                        err_n = 1'b0;
                        state_n = cfg_zero ? DONE : ARM;
                    end
                end
                ARM: begin
                    if (period_tick) begin
                        state_n = RUN;
                        del_n   = sh_start;
                        pt_n    = '0;
                        shot_n  = '0;
                        arm_n   = 1'b1;
                    end
                end
                RUN: begin
                    if (period_tick) begin
                        if (!last_shot) begin
                            shot_n = shot_q + CW'(1);
                        end else if (last_point) begin
                            state_n = DONE;
                            arm_n   = 1'b0;
                        end else if (nxt_del[DW]) begin
                            state_n = DONE;
                            arm_n   = 1'b0;
                            err_n   = 1'b1;
                        end else begin
                            del_n  = nxt_del[DW-1:0];
                            pt_n   = pt_q + CW'(1);
                            shot_n = '0;
                        end
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                    arm_n   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            del_q   <= DW'(DEL_RST);
            pt_q    <= '0;
            shot_q  <= '0;
            arm_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            del_q   <= del_n;
            pt_q    <= pt_n;
            shot_q  <= shot_n;
            arm_q   <= arm_n;
            err_q   <= err_n;
            busy_q  <= (state_n == ARM) || (state_n == RUN);
            done_q  <= (state_n == DONE);
        end
    end

    assign del       = del_q;
    assign arm       = arm_q;
    assign point_idx = pt_q;
    assign shot_idx  = shot_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pulse_scan_sequencer.sv
// Directed self-checking bench for pulse_scan_sequencer.
// The scan_down case is exercised only when SCAN_DIR_EN is defined.
module tb_pulse_scan_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        period_tick = 1'b0;
    logic [15:0] del_start = '0;
    logic [15:0] del_step = '0;
    logic [15:0] n_points = '0;
    logic [15:0] n_shots = '0;
`ifdef SCAN_DIR_EN
    logic        scan_down = 1'b0;
`endif
    logic [15:0] del;
    logic        arm;
    logic [15:0] point_idx;
    logic [15:0] shot_idx;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    pulse_scan_sequencer dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .period_tick(period_tick),
`ifdef SCAN_DIR_EN
        .scan_down(scan_down),
`endif
        .del_start(del_start),
        .del_step(del_step),
        .n_points(n_points),
        .n_shots(n_shots),
        .del(del),
        .arm(arm),
        .point_idx(point_idx),
        .shot_idx(shot_idx),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
        cyc();
    endtask

    task automatic go(input logic [15:0] s, input logic [15:0] st,
                      input logic [15:0] np, input logic [15:0] ns);
        del_start = s;
        del_step  = st;
        n_points  = np;
        n_shots   = ns;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    logic [15:0] exp_del [5];
    logic        saw_done;

    initial begin
        exp_del[0] = 16'd100;
        exp_del[1] = 16'd150;
        exp_del[2] = 16'd150;
        exp_del[3] = 16'd200;
        exp_del[4] = 16'd200;

        #1;
        check("rst_del", del, 0);
        check("rst_arm", arm, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_pt", point_idx, 0);
        cyc();
        reset = 1'b0;
        cyc();

        // Normal scan
        go(16'd100, 16'd50, 16'd3, 16'd2);
        check("n_busy_arm", busy, 1);
        check("n_arm_pre", arm, 0);
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
        check("n_t1_del", del, 100);
        check("n_t1_arm", arm, 1);
        check("n_t1_pt", point_idx, 0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("n_seq%0d", i), del, exp_del[i]);
        end
        check("n_pt2", point_idx, 2);
        check("n_shot1", shot_idx, 1);
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
        check("n_done", done, 1);
        check("n_end_arm", arm, 0);
        check("n_end_err", err, 0);
        check("n_end_del", del, 200);
        check("n_end_busy", busy, 0);
        cyc();
        check("n_done_1cyc", done, 0);

        // Overflow
        go(16'hFFF0, 16'h0020, 16'd3, 16'd1);
        tick();
        check("o_t1_del", del, 16'hFFF0);
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
        check("o_err", err, 1);
        check("o_done", done, 1);
        check("o_del", del, 16'hFFF0);
        check("o_pt", point_idx, 0);
        check("o_arm", arm, 0);
        cyc();
        check("o_err_sticky", err, 1);

        // Zero point count; start also clears err
        go(16'd7, 16'd1, 16'd0, 16'd4);
        check("z_done", done, 1);
        check("z_err_clr", err, 0);
        check("z_arm", arm, 0);
        check("z_busy", busy, 0);
        cyc();
        check("z_done_off", done, 0);
        check("z_arm2", arm, 0);

        // Abort at point 1, shot 0
        go(16'd100, 16'd50, 16'd3, 16'd2);
        tick();
        tick();
        tick();
        check("a_pre_pt", point_idx, 1);
        check("a_pre_shot", shot_idx, 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("a_arm", arm, 0);
        check("a_busy", busy, 0);
        check("a_done", done, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        check("a_hold_del", del, 150);
        check("a_hold_pt", point_idx, 1);
        check("a_hold_shot", shot_idx, 0);
        check("a_no_done", saw_done, 0);

        // Start with tick in the same IDLE cycle
        del_start = 16'd300;
        del_step  = 16'd10;
        n_points  = 16'd2;
        n_shots   = 16'd1;
        start = 1'b1;
        period_tick = 1'b1;
        cyc();
        start = 1'b0;
        period_tick = 1'b0;
        check("c_busy", busy, 1);
        check("c_arm0", arm, 0);
        cyc();
        check("c_still_arm", arm, 0);
        tick();
        check("c_arm1", arm, 1);
        check("c_del", del, 300);

        // Start while busy leaves the snapshot untouched
        del_start = 16'd500;
        del_step  = 16'd99;
        n_points  = 16'd9;
        start = 1'b1;
        cyc();
        start = 1'b0;
        tick();
        check("b_del_next", del, 310);
        check("b_pt", point_idx, 1);
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
        check("b_done", done, 1);
        cyc();

        // Abort and start together in IDLE
        abort = 1'b1;
        start = 1'b1;
        cyc();
        abort = 1'b0;
        start = 1'b0;
        check("as_busy", busy, 0);
        check("as_done", done, 0);

        // Asynchronous reset mid-scan
        go(16'd100, 16'd50, 16'd3, 16'd2);
        tick();
        check("r_arm_pre", arm, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("r_arm", arm, 0);
        check("r_del", del, 0);
        check("r_busy", busy, 0);
        cyc();
        reset = 1'b0;
        cyc();

`ifdef SCAN_DIR_EN
        scan_down = 1'b1;
        go(16'd100, 16'd60, 16'd3, 16'd1);
        scan_down = 1'b0;
        tick();
        check("d_del0", del, 100);
        tick();
        check("d_del1", del, 40);
        period_tick = 1'b1;
        cyc();
        period_tick = 1'b0;
        check("d_err", err, 1);
        check("d_done", done, 1);
        check("d_del", del, 40);
        cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
